load_response_unit: RTL and testbench
=====================================

# load_response_unit

Tracks outstanding loads issued to the memory sub-units and reassembles their responses into writeback results. Sits directly downstream of the load/store queue's transaction output: on each accepted load it records the ID, byte offset and fn3. When the in-order memory response returns, it aligns and sign/zero-extends the data and presents an ID-tagged result to the writeback stage. Stores never enter this block.

## Interface
Parameters:
- DEPTH, 4, maximum outstanding loads; power of two, ≥2
- ID_W, 3, width of instruction ID (matches id_t)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  load accepted by memory sub-unit this cycle
- req_ready  out  1  space for a new outstanding load
- req_id  in  ID_W  ID of the issuing load
- req_addr_lo  in  2  address bits [1:0]
- req_fn3  in  3  RISC-V load fn3
- rsp_valid  in  1  memory read data valid; cannot be stalled
- rsp_data  in  32  raw 32-bit word from memory
- wb_valid  out  1  aligned result available
- wb_id  out  ID_W  ID of the result
- wb_data  out  32  aligned, extended load result
- wb_ack  in  1  writeback consumed the result this cycle
- empty  out  1  no outstanding or buffered loads

## Operation
- Storage: circular buffer of DEPTH entries {id, addr_lo, fn3, data[31:0], data_valid}. Three pointers, each log2(DEPTH) bits, wrap modulo DEPTH:
  - alloc_ptr: advanced on req_valid & req_ready
  - rsp_ptr: advanced on rsp_valid
  - pop_ptr: advanced when the head moves to the output register
- count: log2(DEPTH)+1 bits; +1 on allocate, -1 on pop, unchanged when both occur.
- req_ready = (count != DEPTH). It is computed from the registered count, so a simultaneous pop does not make a full buffer ready.
- Allocate: write id/addr_lo/fn3 at alloc_ptr and clear data_valid.
- Response: write rsp_data at rsp_ptr and set data_valid. Responses return in issue order.
- Output register, loaded when head data_valid & count≠0 & (~wb_valid | wb_ack). Loading pops the head.
- Alignment, byte b = addr_lo, half h = addr_lo[1]:
  - LB 000: sign-extend byte b
  - LH 001: sign-extend half h
  - LW 010: full word
  - LBU 100: zero-extend byte b
  - LHU 101: zero-extend half h
  - other fn3: treat as LW
- Misaligned halfword (addr_lo[0]=1) is not checked; hardware uses half h.
- empty = (count==0) & ~wb_valid.
- Protocol errors are simulation assertions only and must not corrupt state:
  - rsp_valid with no allocated entry awaiting data: response ignored, rsp_ptr does not advance.
  - req_valid while ~req_ready: request dropped.
- No flush input. Global control drains (waits for empty) before flushing in-flight loads.

## Timing
- Reset values: wb_valid=0, wb_id=0, wb_data=0, req_ready=1, empty=1, count=0, all pointers 0, all data_valid cleared.
- Reset mid-operation discards all entries and any pending output. A rsp_valid arriving in the same cycle as rst is ignored.
- Latency: rsp_valid in cycle N gives wb_valid in cycle N+1 when the output register is free or acked in cycle N.
- Earliest response is the cycle after allocation. A response in the same cycle as its own allocation is illegal.
- Throughput: one result per cycle with wb_ack held high.
- wb_valid/wb_id/wb_data hold stable until the cycle wb_ack is sampled high.
- Allocate, response and pop may all occur in one cycle on distinct or equal-index entries. Allocation at index i while a pop frees index i is impossible because req_ready uses the pre-pop count.

## Test plan
- Single LW: req id=3, addr_lo=0, fn3=010; rsp 0x89ABCDEF next cycle -> wb_valid the cycle after, wb_id=3, wb_data=0x89ABCDEF, empty=1 after ack.
- Extension: rsp 0x80FF7F01.
  - LB at offsets 0..3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - LBU offset 3 -> 0x00000080.
  - LH offset 2 -> 0xFFFF80FF.
  - LHU offset 0 -> 0x00007F01.
- Full/backpressure: DEPTH=4, issue ids 0-3 with wb_ack=0 -> req_ready=0 after the 4th. All 4 responses buffered. Release ack -> results 0,1,2,3 on consecutive cycles. req_ready returns 1 the cycle after the first pop.
- Simultaneous events: steady stream with req, rsp and ack every cycle for 20 loads across pointer wrap -> in-order ids, correct data, count constant.
- Reset mid-operation: 3 outstanding, one wb_valid pending; assert rst -> next cycle wb_valid=0, req_ready=1, empty=1. A subsequent single load completes normally.
- Spurious response: rsp_valid with empty buffer -> no wb_valid, pointers unchanged, assertion fires.

Source files
------------

// File: rtl/load_response_unit.sv
// load_response_unit: tracks outstanding loads, captures their in-order memory
// responses and presents aligned, sign/zero-extended, ID-tagged writeback results.
// Ports: req_* (load accepted by memory, req_ready = buffer not full),
//        rsp_* (raw read word, cannot stall), wb_* (result, held until wb_ack),
//        empty (nothing outstanding and no result pending).
// Latency: rsp_valid in cycle N -> wb_valid in N+1 when the output register is free.
module load_response_unit #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ID_W-1:0] req_id,
  input  logic [1:0]      req_addr_lo,
  input  logic [2:0]      req_fn3,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_data,
  output logic            wb_valid,
  output logic [ID_W-1:0] wb_id,
  output logic [31:0]     wb_data,
  input  logic            wb_ack,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      addr_lo;
    logic [2:0]      fn3;
    logic [31:0]     data;
    logic            data_valid;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  logic [PW-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]   rsp_ptr_q, rsp_ptr_d;
  logic [PW-1:0]   pop_ptr_q, pop_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            wb_valid_q, wb_valid_d;
  logic [ID_W-1:0] wb_id_q, wb_id_d;
  logic [31:0]     wb_data_q, wb_data_d;

  logic        alloc_fire, rsp_slot, rsp_fire, head_dv, head_bypass, out_free, pop_fire;
  logic [31:0] head_word;

  function automatic logic [31:0] align(input logic [31:0] w, input logic [1:0] a,
                                        input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    // Misaligned halfwords are not trapped here; addr_lo[0] is simply ignored.
    h = a[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    req_ready  = (count_q != FULL_CNT);
    alloc_fire = req_valid & req_ready;

    // Entries between rsp_ptr and alloc_ptr await data. Equal pointers are
    // ambiguous only when full: then the slot is awaiting iff it has no data yet.
    rsp_slot = (rsp_ptr_q != alloc_ptr_q) |
               ((count_q == FULL_CNT) & ~ent_q[rsp_ptr_q].data_valid);
    rsp_fire = rsp_valid & rsp_slot;

    // A response landing on the head goes straight to the output register,
    // giving single-cycle response-to-writeback latency.
    head_dv     = ent_q[pop_ptr_q].data_valid;
    head_bypass = rsp_fire & (rsp_ptr_q == pop_ptr_q);
    head_word   = head_dv ? ent_q[pop_ptr_q].data : rsp_data;
    out_free    = ~wb_valid_q | wb_ack;
    pop_fire    = (count_q != '0) & (head_dv | head_bypass) & out_free;

    ent_d       = ent_q;
    alloc_ptr_d = alloc_ptr_q;
    rsp_ptr_d   = rsp_ptr_q;
    pop_ptr_d   = pop_ptr_q;
    count_d     = count_q;
    wb_valid_d  = wb_valid_q;
    wb_id_d     = wb_id_q;
    wb_data_d   = wb_data_q;

    if (alloc_fire) begin
      ent_d[alloc_ptr_q].id         = req_id;
      ent_d[alloc_ptr_q].addr_lo    = req_addr_lo;
      ent_d[alloc_ptr_q].fn3        = req_fn3;
      ent_d[alloc_ptr_q].data_valid = 1'b0;
      alloc_ptr_d                   = alloc_ptr_q + PW'(1);
    end

    if (rsp_fire) begin
      ent_d[rsp_ptr_q].data       = rsp_data;
      ent_d[rsp_ptr_q].data_valid = 1'b1;
      rsp_ptr_d                   = rsp_ptr_q + PW'(1);
    end

    if (pop_fire) begin
      wb_valid_d = 1'b1;
      wb_id_d    = ent_q[pop_ptr_q].id;
      wb_data_d  = align(head_word, ent_q[pop_ptr_q].addr_lo, ent_q[pop_ptr_q].fn3);
      pop_ptr_d  = pop_ptr_q + PW'(1);
    end else if (wb_ack) begin
      wb_valid_d = 1'b0;
    end

    case ({alloc_fire, pop_fire})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      alloc_ptr_q <= '0;
      rsp_ptr_q   <= '0;
      pop_ptr_q   <= '0;
      count_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_id_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      alloc_ptr_q <= alloc_ptr_d;
      rsp_ptr_q   <= rsp_ptr_d;
      pop_ptr_q   <= pop_ptr_d;
      count_q     <= count_d;
      wb_valid_q  <= wb_valid_d;
      wb_id_q     <= wb_id_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_id    = wb_id_q;
  assign wb_data  = wb_data_q;
  assign empty    = (count_q == '0) & ~wb_valid_q;

  // Protocol violations are flagged but never alter state.
  assert property (@(posedge clk) disable iff (rst) rsp_valid |-> rsp_slot)
    else $warning("load_response_unit: response with no load awaiting data, ignored");
  assert property (@(posedge clk) disable iff (rst) req_valid |-> req_ready)
    else $warning("load_response_unit: load request while full, dropped");

endmodule

// File: tb/tb_load_response_unit.sv
module tb_load_response_unit;
  localparam int ID_W = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [ID_W-1:0] req_id = '0;
  logic [1:0]      req_addr_lo = '0;
  logic [2:0]      req_fn3 = '0;
  logic            rsp_valid = 1'b0;
  logic [31:0]     rsp_data = '0;
  logic            wb_valid;
  logic [ID_W-1:0] wb_id;
  logic [31:0]     wb_data;
  logic            wb_ack = 1'b0;
  logic            empty;

  int checks = 0;
  int errors = 0;
  logic req_drop = 1'b0;

  // Reference model: loads waiting for data, expected results, observed results.
  logic [ID_W-1:0] pend_id[$];
  logic [1:0]      pend_a[$];
  logic [2:0]      pend_f[$];
  logic [ID_W-1:0] exp_id[$];
  logic [31:0]     exp_dat[$];
  logic [ID_W-1:0] obs_id[$];
  logic [31:0]     obs_dat[$];

  load_response_unit #(.DEPTH(4), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_addr_lo(req_addr_lo), .req_fn3(req_fn3),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_ack(wb_ack),
    .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f);
    logic [31:0] b;
    logic [31:0] h;
    int ia;
    ia = int'(a);
    b = (w >> (8 * ia)) & 32'h0000_00FF;
    h = (w >> (16 * (ia / 2))) & 32'h0000_FFFF;
    case (f)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic clear_model();
    pend_id.delete(); pend_a.delete(); pend_f.delete();
    exp_id.delete(); exp_dat.delete(); obs_id.delete(); obs_dat.delete();
  endtask

  task automatic idle();
    req_valid = 1'b0; rsp_valid = 1'b0; wb_ack = 1'b0; req_drop = 1'b0;
  endtask

  // Advance one clock; the model tracks what the bench drove this cycle.
  task automatic tick();
    if (!rst) begin
      if (wb_valid && wb_ack) begin
        obs_id.push_back(wb_id);
        obs_dat.push_back(wb_data);
      end
      if (req_valid && !req_drop) begin
        pend_id.push_back(req_id); pend_a.push_back(req_addr_lo); pend_f.push_back(req_fn3);
      end
      if (rsp_valid && pend_id.size() > 0) begin
        exp_id.push_back(pend_id.pop_front());
        exp_dat.push_back(model_load(rsp_data, pend_a.pop_front(), pend_f.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input logic [ID_W-1:0] id);
    logic [2:0] fsel [8];
    fsel = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    req_valid   = 1'b1;
    req_id      = id;
    req_addr_lo = 2'($urandom_range(0, 3));
    req_fn3     = fsel[$urandom_range(0, 7)];
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (wb_id !== '0) begin errors++; $display("FAIL reset_wb_id: got %0d want 0", wb_id); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_lw();
    clear_model(); idle();
    req_valid = 1'b1; req_id = 3'd3; req_addr_lo = 2'd0; req_fn3 = 3'b010;
    tick();
    req_valid = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lw_early_valid: got %b want 0", wb_valid); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL lw_busy_empty: got %b want 0", empty); end
    rsp_valid = 1'b1; rsp_data = 32'h89AB_CDEF;
    tick();
    rsp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lw_valid: got %b want 1", wb_valid); end
    checks++; if (wb_id !== 3'd3) begin errors++; $display("FAIL lw_id: got %0d want 3", wb_id); end
    checks++; if (wb_data !== 32'h89AB_CDEF) begin errors++; $display("FAIL lw_data: got %h want 89abcdef", wb_data); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lw_after_ack_valid: got %b want 0", wb_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lw_after_ack_empty: got %b want 1", empty); end
  endtask

  task automatic test_extension();
    logic [1:0]  ta [7];
    logic [2:0]  tf [7];
    logic [31:0] te [7];
    ta = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0};
    tf = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
    te = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
           32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    clear_model(); idle();
    for (int k = 0; k < 7; k++) begin
      req_valid = 1'b1; req_id = 3'(k); req_addr_lo = ta[k]; req_fn3 = tf[k];
      tick();
      req_valid = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h80FF_7F01;
      tick();
      rsp_valid = 1'b0;
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== te[k])
        begin errors++; $display("FAIL ext_%0d: got valid=%b data=%h want valid=1 data=%h", k, wb_valid, wb_data, te[k]); end
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
    end
  endtask

  task automatic test_full();
    clear_model(); idle();
    for (int k = 0; k < 4; k++) begin
      rand_req(3'(k));
      tick();
    end
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
    // A request while full must be dropped without disturbing state.
    req_valid = 1'b1; req_drop = 1'b1; req_id = 3'd7; req_addr_lo = 2'd0; req_fn3 = 3'b010;
    tick();
    req_valid = 1'b0; req_drop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rsp_valid = 1'b1; rsp_data = $urandom;
      tick();
      if (k == 0) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", req_ready); end
      end
    end
    rsp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_id !== 3'd0)
        begin errors++; $display("FAIL full_hold_%0d: got valid=%b id=%0d want valid=1 id=0", c, wb_valid, wb_id); end
      tick();
    end
    wb_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_id !== 3'(k))
        begin errors++; $display("FAIL full_drain_%0d: got valid=%b id=%0d want valid=1 id=%0d", k, wb_valid, wb_id, k); end
      tick();
    end
    wb_ack = 1'b0;
    checks++; if (empty !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL full_end_empty: got empty=%b valid=%b want 1/0", empty, wb_valid); end
    checks++; if (obs_id.size() != 4) begin errors++; $display("FAIL full_count: got %0d results want 4", obs_id.size()); end
    foreach (exp_id[i]) if (i < obs_id.size()) begin
      checks++;
      if (obs_id[i] !== exp_id[i] || obs_dat[i] !== exp_dat[i])
        begin errors++; $display("FAIL full_result_%0d: got id=%0d data=%h want id=%0d data=%h", i, obs_id[i], obs_dat[i], exp_id[i], exp_dat[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_model(); idle();
    wb_ack = 1'b1;
    for (int t = 0; t < 22; t++) begin
      if (t < 20) rand_req(3'(t % 8)); else req_valid = 1'b0;
      rsp_valid = (t >= 1 && t <= 20);
      rsp_data  = $urandom;
      if (t >= 2) begin
        checks++;
        if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_t%0d: got %b want 1", t, wb_valid); end
      end
      if (t >= 1) begin
        checks++;
        if (req_ready !== 1'b1 || empty !== 1'b0)
          begin errors++; $display("FAIL b2b_occupancy_t%0d: got ready=%b empty=%b want 1/0", t, req_ready, empty); end
      end
      tick();
    end
    idle();
    checks++; if (obs_id.size() != 20) begin errors++; $display("FAIL b2b_count: got %0d results want 20", obs_id.size()); end
    foreach (exp_id[i]) if (i < obs_id.size()) begin
      checks++;
      if (obs_id[i] !== exp_id[i] || obs_dat[i] !== exp_dat[i])
        begin errors++; $display("FAIL b2b_result_%0d: got id=%0d data=%h want id=%0d data=%h", i, obs_id[i], obs_dat[i], exp_id[i], exp_dat[i]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_end_empty: got %b want 1", empty); end
  endtask

  task automatic test_spurious();
    clear_model(); idle();
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL spur_valid: got %b want 0", wb_valid); end
    checks++; if (empty !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL spur_state: got empty=%b ready=%b want 1/1", empty, req_ready); end
    rand_req(3'd5);
    tick();
    req_valid = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL spur_next_early: got %b want 0", wb_valid); end
    rsp_valid = 1'b1; rsp_data = $urandom;
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || exp_id.size() != 1 || wb_id !== 3'd5 || wb_data !== exp_dat[0])
      begin errors++; $display("FAIL spur_next_result: got valid=%b id=%0d data=%h want valid=1 id=5 data=%h", wb_valid, wb_id, wb_data, exp_dat[0]); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_model(); idle();
    for (int k = 0; k < 4; k++) begin
      rand_req(3'(k + 4));
      tick();
    end
    req_valid = 1'b0;
    rsp_valid = 1'b1; rsp_data = $urandom;
    tick();
    rsp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %b want 1", wb_valid); end
    rst = 1'b1; rsp_valid = 1'b1; rsp_data = $urandom;
    tick();
    rst = 1'b0; rsp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", wb_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b want 1", empty); end
    clear_model();
    rand_req(3'd2);
    tick();
    req_valid = 1'b0; rsp_valid = 1'b1; rsp_data = $urandom;
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || exp_id.size() != 1 || wb_id !== 3'd2 || wb_data !== exp_dat[0])
      begin errors++; $display("FAIL rmid_after: got valid=%b id=%0d data=%h want valid=1 id=2 data=%h", wb_valid, wb_id, wb_data, exp_dat[0]); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_final_empty: got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single_lw();
    test_extension();
    test_full();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
